// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns {a,b,c,d,e,f,g} (bit6=a, bit0=g), blank pattern, anode-off helper
// and the nibble decode function used by hex_to_seg7.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Widest display the driver supports; callers slice the anode mask down.
    localparam int MAX_DIGITS = 8;

    // All anodes released (active-low, so all ones) for the widest display.
    function automatic logic [MAX_DIGITS-1:0] anode_off();
        return {MAX_DIGITS{1'b1}};
    endfunction

    // Hex nibble to active-low cathode pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Pure table lookup on the selected nibble.
    always_comb begin
        seg_o = seg_decode(nibble_i);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver. Digits are
// scanned round-robin, each slot opening with a dead-time gap with every
// anode off. Display inputs are captured once per frame (slot 0, cycle 0)
// so a frame never mixes old and new values.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEADTIME    = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic                      lzb_en,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                ca,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      DEAD_END = CNT_W'(DEADTIME);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [MAX_DIGITS-1:0] AN_OFF_FULL = anode_off();
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_OFF_FULL[NUM_DIGITS-1:0];

    // Scan position
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    // Frame snapshot
    logic [4*NUM_DIGITS-1:0] snap_value_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;
    logic [NUM_DIGITS-1:0]   snap_blank_q;
    logic                    snap_lzb_q;
    logic                    take_snap_s;

    // Digit selection / blanking
    logic [NUM_DIGITS-1:0]   lead_zero_s;
    logic [NUM_DIGITS-1:0]   digit_blank_s;
    logic [NUM_DIGITS-1:0]   an_sel_s;
    logic [3:0]              nib_s;
    logic                    sel_dp_s;
    logic                    sel_blank_s;
    logic [6:0]              seg_s;

    // Output registers
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              ca_q, ca_d;
    logic                    dp_q, dp_d;
    logic                    frame_start_q, frame_start_d;

    // Slot counter wraps at REFRESH_DIV-1 and advances the digit index.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // The first cycle of digit 0's slot is the frame boundary.
    always_comb begin
        take_snap_s = (cnt_q == '0) && (idx_q == '0);
    end

    // Leading-zero map (scanning down from the MSD) and per-digit blank.
    always_comb begin
        logic run_zero;
        run_zero      = 1'b1;
        lead_zero_s   = '0;
        digit_blank_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero       = run_zero && (snap_value_q[4*i +: 4] == 4'h0);
            lead_zero_s[i] = run_zero;
            // Digit 0 is never leading-zero blanked so zero reads as "0".
            if (i != 0) begin
                digit_blank_s[i] = snap_blank_q[i] | (snap_lzb_q & lead_zero_s[i]);
            end else begin
                digit_blank_s[i] = snap_blank_q[i];
            end
        end
    end

    // Mux out the active digit's nibble, dp request, blank flag and anode.
    always_comb begin
        nib_s       = 4'h0;
        sel_dp_s    = 1'b0;
        sel_blank_s = 1'b0;
        an_sel_s    = AN_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_s       = snap_value_q[4*i +: 4];
                sel_dp_s    = snap_dp_q[i];
                sel_blank_s = digit_blank_s[i];
                an_sel_s[i] = 1'b0;
            end else begin
                an_sel_s[i] = 1'b1;
            end
        end
    end

    hex_to_seg7 u_dec (
        .nibble_i (nib_s),
        .seg_o    (seg_s)
    );

    // Next output values: dark during dead time or when disabled.
    always_comb begin
        an_d          = AN_OFF;
        ca_d          = SEG_BLANK;
        dp_d          = 1'b1;
        frame_start_d = take_snap_s;
        if (!en || (cnt_q < DEAD_END)) begin
            an_d = AN_OFF;
            ca_d = SEG_BLANK;
            dp_d = 1'b1;
        end else begin
            an_d = an_sel_s;
            ca_d = sel_blank_s ? SEG_BLANK : seg_s;
            dp_d = sel_blank_s ? 1'b1 : ~sel_dp_s;
        end
    end

    // Scan counters and output registers; reset aborts any slot in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            an_q          <= AN_OFF;
            ca_q          <= SEG_BLANK;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            an_q          <= an_d;
            ca_q          <= ca_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Frame snapshot of the display inputs, held for a whole frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_value_q <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= '0;
            snap_lzb_q   <= 1'b0;
        end else if (take_snap_s) begin
            snap_value_q <= value;
            snap_dp_q    <= dp_in;
            snap_blank_q <= blank;
            snap_lzb_q   <= lzb_en;
        end else begin
            snap_value_q <= snap_value_q;
            snap_dp_q    <= snap_dp_q;
            snap_blank_q <= snap_blank_q;
            snap_lzb_q   <= snap_lzb_q;
        end
    end

    assign an          = an_q;
    assign ca          = ca_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 dead).
// Each frame's hand-computed digit patterns are queued up front; a monitor
// pops one entry every cycle in which any anode is driven low.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int DT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        lzb_en = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  an;
    logic [6:0]  ca;
    logic        dp;
    logic        frame_start;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .DEADTIME    (DT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .value       (value),
        .dp_in       (dp_in),
        .blank       (blank),
        .lzb_en      (lzb_en),
        .an          (an),
        .ca          (ca),
        .dp          (dp),
        .frame_start (frame_start)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Monitor: every lit-digit cycle must match the next queued pattern.
    always @(negedge clk) begin
        logic [11:0] e;
        if (an !== 4'hF) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_digit: got an=%b ca=%b dp=%b, expected anodes off (t=%0t)",
                         an, ca, dp, $time);
            end else begin
                e = exp_q.pop_front();
                check("digit{an,ca,dp}", {20'h0, an, ca, dp}, {20'h0, e});
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_an", {28'h0, an}, 32'h0000000F);
            check("rst_ca", {25'h0, ca}, 32'h0000007F);
            check("rst_dp", {31'h0, dp}, 32'h00000001);
            check("rst_fs", {31'h0, frame_start}, 32'h00000000);
        end
        rst_n = 1'b1;
    endtask

    // One 32-cycle frame, called on the negedge just before a snapshot edge.
    // eca = {d3,d2,d1,d0} cathodes, edp = per-digit active-low dp.
    task automatic frame(input logic [15:0] v, input logic [3:0] dpi, input logic [3:0] blk,
                         input logic lzb, input logic [27:0] eca, input logic [3:0] edp,
                         input int tear_at, input logic [15:0] alt,
                         input int en_from, input int en_to, input int rst_at);
        int limit;
        logic [3:0] an_e;
        logic [6:0] ca_e;
        value  = v;
        dp_in  = dpi;
        blank  = blk;
        lzb_en = lzb;
        limit  = (rst_at != 0) ? rst_at : 32;
        // Digit d is lit on edges 8d+3 .. 8d+8 of the frame.
        for (int d = 0; d < 4; d++) begin
            for (int s = 3; s <= 8; s++) begin
                int k;
                k = 8 * d + s;
                if ((k <= limit) && !((k > en_from) && (k <= en_to))) begin
                    an_e = ~(4'b0001 << d);
                    ca_e = eca[7*d +: 7];
                    exp_q.push_back({an_e, ca_e, edp[d]});
                end
            end
        end
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            check("frame_start", {31'h0, frame_start}, {31'h0, (n == 1)});
            if ((n % 8 == 1) || (n % 8 == 2)) begin
                check("deadtime_an", {28'h0, an}, 32'h0000000F);
            end
            if ((n > en_from) && (n <= en_to)) begin
                check("en_off_an", {28'h0, an}, 32'h0000000F);
            end
            if ((en_from != 0) && (n == en_from)) en = 1'b0;
            if ((en_to != 0) && (n == en_to)) en = 1'b1;
            if (n == tear_at) value = alt;
            if (n == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("midrst_an", {28'h0, an}, 32'h0000000F);
                check("midrst_ca", {25'h0, ca}, 32'h0000007F);
                check("midrst_dp", {31'h0, dp}, 32'h00000001);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        do_reset();
        // Basic scan of 12AF with dp on digit 2, twice to show repetition.
        frame(16'h12AF, 4'b0100, 4'h0, 1'b0, {7'h4F, 7'h12, 7'h08, 7'h38}, 4'b1011, 0, 16'h0, 0, 0, 0);
        frame(16'h12AF, 4'b0100, 4'h0, 1'b0, {7'h4F, 7'h12, 7'h08, 7'h38}, 4'b1011, 0, 16'h0, 0, 0, 0);
        // Tear-free: value changes during digit 2's slot, frame keeps 1234.
        frame(16'h1234, 4'h0, 4'h0, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'hF, 20, 16'h5678, 0, 0, 0);
        frame(16'h5678, 4'h0, 4'h0, 1'b0, {7'h24, 7'h20, 7'h0F, 7'h00}, 4'hF, 0, 16'h0, 0, 0, 0);
        // Leading-zero blanking.
        frame(16'h0030, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h06, 7'h01}, 4'hF, 0, 16'h0, 0, 0, 0);
        frame(16'h0000, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'hF, 0, 16'h0, 0, 0, 0);
        frame(16'h0400, 4'hF, 4'h0, 1'b1, {7'h7F, 7'h4C, 7'h01, 7'h01}, 4'b1000, 0, 16'h0, 0, 0, 0);
        // Forced blank of digit 0 overrides its dp request.
        frame(16'h9BCD, 4'b0001, 4'b0001, 1'b0, {7'h04, 7'h60, 7'h31, 7'h7F}, 4'hF, 0, 16'h0, 0, 0, 0);
        // Enable dropped for 10 cycles mid-frame; scan resumes in place.
        frame(16'h3E08, 4'h0, 4'h0, 1'b0, {7'h06, 7'h30, 7'h01, 7'h00}, 4'hF, 0, 16'h0, 4, 14, 0);
        // Reset while digit 2 is lit, then a fresh frame from digit 0.
        frame(16'hC0DE, 4'b1000, 4'h0, 1'b0, {7'h31, 7'h01, 7'h42, 7'h30}, 4'b0111, 0, 16'h0, 0, 0, 20);
        frame(16'h4321, 4'h0, 4'h0, 1'b0, {7'h4C, 7'h06, 7'h12, 7'h4F}, 4'hF, 0, 16'h0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'h00000000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
